// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } statetype_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode from the controller's ALUOp and the instruction fields.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  // Map ALUOp/funct fields onto an ALU operation
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: begin
            // only R-type with funct7[5] subtracts; addi shares the same bit position
            if (op5 && funct7b5) alu_control = ALU_SUB;
            else                 alu_control = ALU_ADD;
          end
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM with memory handshake, illegal-opcode trap and retire counter.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             RegWrite,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  statetype_t       state_r;
  logic             illegal_r;
  logic [CNT_W-1:0] retired_r;

  logic       branch_s, pc_update_s, ir_write_s, mem_write_s, reg_write_s;
  logic [1:0] alu_op_s;

  // State sequencing, trap flag and retired-instruction count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= FETCH;
      illegal_r <= 1'b0;
      retired_r <= '0;
    end else begin
      if (state_r == TRAP) illegal_r <= 1'b1;
      case (state_r)
        FETCH: if (mem_ready) state_r <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: state_r <= MEMADR;
            OP_R:         state_r <= EXECUTER;
            OP_I:         state_r <= EXECUTEI;
            OP_BEQ:       state_r <= BEQ;
            OP_JAL:       state_r <= JAL;
            default:      state_r <= TRAP;
          endcase
        end
        MEMADR: state_r <= (op == OP_SW) ? MEMWRITE : MEMREAD;
        MEMREAD: if (mem_ready) state_r <= MEMWB;
        MEMWRITE: begin
          if (mem_ready) begin
            state_r   <= FETCH;
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        EXECUTER, EXECUTEI, JAL: state_r <= ALUWB;
        MEMWB, ALUWB, BEQ: begin
          state_r   <= FETCH;
          retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        TRAP:    state_r <= TRAP;
        default: state_r <= FETCH;
      endcase
    end
  end

  // Moore decode of datapath controls from the current state
  always_comb begin
    AdrSrc      = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    alu_op_s    = ALUOP_ADD;
    branch_s    = 1'b0;
    pc_update_s = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    case (state_r)
      FETCH: begin
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALURESULT;
        ir_write_s  = mem_ready;
        pc_update_s = mem_ready;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc   = RES_DATA;
        reg_write_s = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA  = SRCA_RS1;
        alu_op_s = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        ALUSrcA  = SRCA_RS1;
        ALUSrcB  = SRCB_IMM;
        alu_op_s = ALUOP_FUNCT;
      end
      ALUWB: reg_write_s = 1'b1;
      BEQ: begin
        ALUSrcA  = SRCA_RS1;
        alu_op_s = ALUOP_SUB;
        branch_s = 1'b1;
      end
      JAL: begin
        ALUSrcA     = SRCA_OLDPC;
        ALUSrcB     = SRCB_FOUR;
        pc_update_s = 1'b1;
      end
      TRAP:    AdrSrc = 1'b0;
      default: AdrSrc = 1'b0;
    endcase
  end

  // Immediate format from opcode
  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op_s),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );

  // enables are gated by rst_n so nothing writes while reset is held
  assign PCWrite  = rst_n & ((branch_s & zero) | pc_update_s);
  assign IRWrite  = rst_n & ir_write_s;
  assign MemWrite = rst_n & mem_write_s;
  assign RegWrite = rst_n & reg_write_s;
  assign illegal  = illegal_r;
  assign retired  = retired_r;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle RV32I subset core: lw, sw, R-type, I-type ALU, beq, jal.
- Sequences the shared datapath across fetch, decode, execute, memory and writeback cycles.
- Drives register, memory and PC enables plus mux selects. Generates ALUControl and ImmSrc.
- Adds a memory ready handshake, an illegal-opcode trap and a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  7  instruction opcode, instr[6:0], from the instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag
mem_ready  in  1  unified memory completes the current access this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction/OldPC register enable
ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4
RegWrite  out  1  register file write enable
ImmSrc  out  2  immediate format select
ALUControl  out  3  ALU operation code
illegal  out  1  sticky illegal-opcode flag
retired  out  CNT_W  count of completed instructions

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- On reset: state = FETCH, illegal = 0, retired = 0.
- While rst_n = 0, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0 combinationally.
- Output style: Moore outputs from the state register. Any output not listed for a state is 0.
- Per-state outputs:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite = PCUpdate = mem_ready.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
  - TRAP: all enables 0.
- PCWrite = (Branch & zero) | PCUpdate.
- Transitions:
  - FETCH -> DECODE when mem_ready, else hold.
  - DECODE: 0000011/0100011 -> MEMADR, 0110011 -> EXECUTER, 0010011 -> EXECUTEI, 1100011 -> BEQ, 1101111 -> JAL, any other op -> TRAP.
  - MEMADR: lw -> MEMREAD, sw -> MEMWRITE.
  - MEMREAD -> MEMWB when mem_ready, else hold.
  - MEMWRITE -> FETCH when mem_ready, else hold. MemWrite stays high while holding.
  - MEMWB -> FETCH.
  - EXECUTER, EXECUTEI, JAL -> ALUWB -> FETCH.
  - BEQ -> FETCH.
  - TRAP: absorbing. illegal = 1 from the cycle after entry until reset.
- retired increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. It wraps modulo 2^CNT_W.
- ImmSrc is combinational from op: sw = 01, beq = 10, jal = 11, everything else = 00.
- ALUControl is combinational from ALUOp, funct3, funct7b5 and op[5]:
  - ALUOp 00 -> 000 (add); ALUOp 01 -> 001 (sub).
  - ALUOp 10, funct3 000: 001 if op[5] & funct7b5, else 000.
  - ALUOp 10, funct3 010 -> 101 (slt); 110 -> 011 (or); 111 -> 010 (and); any other -> 000.
- Reset mid-access: state returns to FETCH immediately, with no write enable glitch while rst_n is low.
- Cycle counts with mem_ready held at 1: lw 5, sw 4, R/I 4, jal 4, beq 3.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - the state enum statetype_t;
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL;
  - ALUControl constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT;
  - the ResultSrc, ALUSrcA and ALUSrcB encodings.
- One sub-module: alu_decoder, which is purely combinational and is instantiated once.
- ImmSrc decode is inline.

Test Plan:
- lw with mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 and ResultSrc=01 in cycle 5. retired goes 0 -> 1.
- sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 and AdrSrc=1 for 4 cycles, then FETCH. retired increments exactly once.
- beq: zero=1 -> PCWrite=1 in the BEQ cycle. zero=0 -> PCWrite=0. ALUControl=001 and ImmSrc=10 in both cases.
- R-type sub (funct3=000, funct7b5=1) -> ALUControl=001 in EXECUTER. The same fields with op=0010011 -> ALUControl=000 (addi).
- jal -> JAL with PCWrite=1, then ALUWB with RegWrite=1 and ResultSrc=00. ImmSrc=11.
- op=1111111 -> TRAP and illegal=1. Holds with zero enables for 20 cycles. Asserting rst_n=0 mid-MEMREAD -> FETCH, retired=0, all enables 0 while in reset.
